// File: rtl/debug_ctrl_pkg.sv
// Shared types for the debug request controller.
//   cmd_op_e     : host command opcodes
//   rsp_status_e : status returned once per command
//   dbg_state_e  : controller FSM encoding, also exported on state_o
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'd0,
        CMD_HALT      = 2'd1,
        CMD_RESUME    = 2'd2,
        CMD_ACK_RESET = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_TIMEOUT   = 2'd1,
        RSP_ERR_STATE = 2'd2
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HALT_REQ    = 3'd1,
        ST_HALTED      = 3'd2,
        ST_RESUME_WAIT = 3'd3,
        ST_RESP        = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Saturating wait counter for halt/resume acknowledgement.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : load zero (wins over en_i)
//   en_i       : count one cycle
//   expired_o  : counter has reached TIMEOUT_CYCLES-1
module dbg_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != LAST)  // saturate, never wrap
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/debug_req_ctrl.sv
// Drives the core debug request line from host HALT/RESUME/ACK_RESET
// commands and returns one status response per command.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid_i/ready_o : command handshake, cmd_op_i = opcode
//   rsp_valid_o/ready_i : response handshake, rsp_status_o = status
//   debug_req_o         : to core debug_req_i
//   debug_*_i           : core havereset/running/halted status
//   havereset_sticky_o  : latched havereset, cleared by ACK_RESET
//   state_o             : current FSM state
module debug_req_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [1:0] rsp_status_o,
    output logic       debug_req_o,
    input  logic       debug_havereset_i,
    input  logic       debug_running_i,
    input  logic       debug_halted_i,
    output logic       havereset_sticky_o,
    output logic [2:0] state_o
);

    dbg_state_e  state_q, state_d;
    dbg_state_e  ret_q, ret_d;
    dbg_state_e  track_st;
    rsp_status_e status_q, status_d;
    logic        req_q, req_d;
    logic        sticky_q, sticky_d;
    logic        cnt_clr, cnt_en, cnt_expired;
    logic        ack_clr;
    logic        core_running;
    cmd_op_e     op;

    assign op           = cmd_op_e'(cmd_op_i);
    assign core_running = debug_running_i && !debug_halted_i;

    dbg_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        status_d = status_q;
        req_d    = req_q;
        track_st = state_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        ack_clr  = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // Follow the core on its own first; a command this cycle
                // is then decoded against the tracked state.
                if (state_q == ST_IDLE && debug_halted_i)
                    track_st = ST_HALTED;
                else if (state_q == ST_HALTED && core_running)
                    track_st = ST_IDLE;
                state_d = track_st;

                if (cmd_valid_i) begin
                    state_d  = ST_RESP;
                    ret_d    = track_st;
                    status_d = RSP_OK;
                    case (op)
                        CMD_HALT: begin
                            if (track_st == ST_IDLE) begin
                                state_d = ST_HALT_REQ;
                                req_d   = 1'b1;
                                cnt_clr = 1'b1;
                            end
                        end
                        CMD_RESUME: begin
                            if (track_st == ST_HALTED) begin
                                state_d = ST_RESUME_WAIT;
                                cnt_clr = 1'b1;
                            end else begin
                                status_d = RSP_ERR_STATE;
                            end
                        end
                        CMD_ACK_RESET: ack_clr = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_HALT_REQ: begin
                if (debug_halted_i) begin
                    req_d    = 1'b0;
                    status_d = RSP_OK;
                    ret_d    = ST_HALTED;
                    state_d  = ST_RESP;
                end else if (cnt_expired) begin
                    req_d    = 1'b0;
                    status_d = RSP_TIMEOUT;
                    ret_d    = ST_IDLE;
                    state_d  = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_RESUME_WAIT: begin
                if (core_running) begin
                    status_d = RSP_OK;
                    ret_d    = ST_IDLE;
                    state_d  = ST_RESP;
                end else if (cnt_expired) begin
                    status_d = RSP_TIMEOUT;
                    ret_d    = ST_HALTED;
                    state_d  = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready_i)
                    state_d = ret_q;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // A havereset pulse in the same cycle as ACK_RESET must not be lost.
    always_comb begin
        sticky_d = sticky_q;
        if (ack_clr)           sticky_d = 1'b0;
        if (debug_havereset_i) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_IDLE;
            status_q <= RSP_OK;
            req_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            status_q <= status_d;
            req_q    <= req_d;
            sticky_q <= sticky_d;
        end
    end

    assign cmd_ready_o        = (state_q == ST_IDLE) || (state_q == ST_HALTED);
    assign rsp_valid_o        = (state_q == ST_RESP);
    assign rsp_status_o       = status_q;
    assign debug_req_o        = req_q;
    assign havereset_sticky_o = sticky_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_debug_req_ctrl.sv
module tb_debug_req_ctrl;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i = 2'd0;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b1;
    logic [1:0] rsp_status_o;
    logic       debug_req_o;
    logic       debug_havereset_i = 1'b0;
    logic       debug_running_i = 1'b0;
    logic       debug_halted_i = 1'b0;
    logic       havereset_sticky_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;
    int req_cycles = 0;
    int exp_q[$];

    debug_req_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid_i        (cmd_valid_i),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_op_i           (cmd_op_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_status_o       (rsp_status_o),
        .debug_req_o        (debug_req_o),
        .debug_havereset_i  (debug_havereset_i),
        .debug_running_i    (debug_running_i),
        .debug_halted_i     (debug_halted_i),
        .havereset_sticky_o (havereset_sticky_o),
        .state_o            (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count cycles with the debug request line high.
    always @(negedge clk) if (debug_req_o) req_cycles++;

    // Response monitor: every handshake pops one expected status.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got status %0d expected no response", rsp_status_o);
            end else begin
                chk("rsp_status", int'(rsp_status_o), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input int exp, input bit push, input logic hr);
        int t = 0;
        while (!cmd_ready_o && t < 100) begin
            cyc(1);
            t++;
        end
        if (!cmd_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_ready_wait: got ready 0 expected 1 within 100 cycles");
        end
        cmd_valid_i = 1'b1;
        cmd_op_i = op;
        debug_havereset_i = hr;
        if (push) exp_q.push_back(exp);
        cyc(1);
        cmd_valid_i = 1'b0;
        cmd_op_i = 2'd0;
        debug_havereset_i = 1'b0;
    endtask

    initial begin
        int base;
        int t;

        // Reset state
        cyc(3);
        chk("rst_state", int'(state_o), 0);
        chk("rst_req", int'(debug_req_o), 0);
        chk("rst_rsp_valid", int'(rsp_valid_o), 0);
        chk("rst_rsp_status", int'(rsp_status_o), 0);
        chk("rst_sticky", int'(havereset_sticky_o), 0);
        chk("rst_cmd_ready", int'(cmd_ready_o), 1);
        rst = 1'b0;
        cyc(1);

        // HALT, core halts 3 cycles after the request rises
        base = req_cycles;
        issue(2'd1, 0, 1, 1'b0);
        chk("halt_req_high", int'(debug_req_o), 1);
        cyc(2);
        debug_halted_i = 1'b1;
        cyc(4);
        chk("halt_req_cycles", req_cycles - base, 3);
        chk("halt_state", int'(state_o), 2);
        chk("halt_cmd_ready", int'(cmd_ready_o), 1);

        // RESUME from HALTED, core runs after 5 cycles
        issue(2'd2, 0, 1, 1'b0);
        chk("resume_wait_state", int'(state_o), 3);
        cyc(4);
        debug_halted_i = 1'b0;
        debug_running_i = 1'b1;
        cyc(4);
        chk("resume_state", int'(state_o), 0);

        // RESUME in IDLE is an error, no request activity
        base = req_cycles;
        issue(2'd2, 2, 1, 1'b0);
        cyc(3);
        chk("resume_idle_req", req_cycles - base, 0);
        chk("resume_idle_state", int'(state_o), 0);

        // HALT that never completes times out after TMO cycles
        base = req_cycles;
        issue(2'd1, 1, 1, 1'b0);
        cyc(TMO + 6);
        chk("tmo_req_cycles", req_cycles - base, TMO);
        chk("tmo_state", int'(state_o), 0);
        chk("tmo_req_low", int'(debug_req_o), 0);

        // Sticky havereset
        debug_havereset_i = 1'b1;
        cyc(1);
        debug_havereset_i = 1'b0;
        chk("sticky_set", int'(havereset_sticky_o), 1);
        issue(2'd3, 0, 1, 1'b1);
        chk("sticky_set_wins", int'(havereset_sticky_o), 1);
        cyc(2);
        issue(2'd3, 0, 1, 1'b0);
        chk("sticky_cleared", int'(havereset_sticky_o), 0);
        cyc(2);
        chk("ack_state", int'(state_o), 0);

        // Stalled response stays stable and blocks commands
        rsp_ready_i = 1'b0;
        issue(2'd2, 2, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(rsp_valid_o), 1);
            chk("stall_status", int'(rsp_status_o), 2);
            chk("stall_cmd_ready", int'(cmd_ready_o), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        cyc(3);
        chk("stall_done_state", int'(state_o), 0);

        // Reset during HALT_REQ drops the response
        debug_running_i = 1'b0;
        issue(2'd1, 0, 0, 1'b0);
        cyc(4);
        chk("pre_rst_req", int'(debug_req_o), 1);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_req", int'(debug_req_o), 0);
        chk("mid_rst_valid", int'(rsp_valid_o), 0);
        chk("mid_rst_state", int'(state_o), 0);
        rst = 1'b0;
        cyc(2);

        // Core halts in IDLE in the same cycle a HALT is accepted
        base = req_cycles;
        debug_halted_i = 1'b1;
        issue(2'd1, 0, 1, 1'b0);
        chk("track_resp_state", int'(state_o), 4);
        cyc(3);
        chk("track_state", int'(state_o), 2);
        chk("track_req_cycles", req_cycles - base, 0);

        // Drain the scoreboard
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            cyc(1);
            t++;
        end
        chk("rsp_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_req_ctrl.md
Name: debug_req_ctrl

Overview:
- Upstream driver of the core's debug port: turns host-side HALT/RESUME/ACK_RESET commands (valid/ready) into the core's debug request input.
- Tracks core halt/run/reset status and returns one status response per command (valid/ready).
- Has a bounded timeout per operation.
- Sits between the test/host sequencer and the core's debug interface: debug_req_o feeds debug_req_i; debug_havereset/running/halted outputs feed back here.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles to wait for halt or run acknowledgement; must be >= 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
- clk  input  1  core clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted when valid&ready at the clk edge.
- cmd_op_i  input  2  0=NOP, 1=HALT, 2=RESUME, 3=ACK_RESET.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when valid&ready.
- rsp_status_o  output  2  0=OK, 1=TIMEOUT, 2=ERR_STATE.
- debug_req_o  output  1  to core debug_req_i.
- debug_havereset_i  input  1  from core.
- debug_running_i  input  1  from core.
- debug_halted_i  input  1  from core.
- havereset_sticky_o  output  1  latched havereset, cleared by ACK_RESET.
- state_o  output  3  current FSM state, for debug and visibility.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE, debug_req_o=0, rsp_valid_o=0, rsp_status_o=0, havereset_sticky_o=0, counter=0. Reset mid-operation drops any pending response and deasserts debug_req_o on the next edge.
- States: IDLE, HALT_REQ, HALTED, RESUME_WAIT, RESP. RESP holds a registered return state.
- cmd_ready_o = 1 only in IDLE or HALTED; combinational from state only.
- Spontaneous tracking, which takes priority over command decode in the same cycle:
  - IDLE with debug_halted_i=1 -> HALTED.
  - HALTED with debug_running_i=1 and debug_halted_i=0 -> IDLE.
  - A command accepted that cycle is decoded against the post-tracking state.
- HALT from IDLE:
  - Next state HALT_REQ; debug_req_o=1 and counter=0 registered at the accept edge.
  - Each edge in HALT_REQ: if debug_halted_i=1 -> debug_req_o=0, status OK, return state HALTED.
  - Else if counter==TIMEOUT_CYCLES-1 -> debug_req_o=0, status TIMEOUT, return state IDLE.
  - Else counter++.
  - Result: debug_req_o is high for min 1 cycle and max TIMEOUT_CYCLES cycles.
- HALT in HALTED: go to RESP immediately with status OK; debug_req_o untouched.
- RESUME in HALTED:
  - Go to RESUME_WAIT, counter=0; debug_req_o stays 0.
  - Completes when debug_running_i=1 and debug_halted_i=0 -> OK, return IDLE.
  - On timeout (same counting rule as HALT) -> TIMEOUT, return HALTED.
- RESUME in IDLE: status ERR_STATE, return IDLE.
- ACK_RESET (IDLE or HALTED): clears havereset_sticky_o, status OK, return to the same state.
- NOP: status OK, return to the same state.
- RESP:
  - rsp_valid_o=1; rsp_status_o stable while valid.
  - On rsp_ready_i, rsp_valid_o drops the next cycle and the FSM enters the return state.
  - The response may wait indefinitely; no new command is accepted meanwhile.
- havereset_sticky_o:
  - Set on any cycle with debug_havereset_i=1.
  - Cleared on ACK_RESET accept.
  - Set wins over clear in the same cycle.
- Counter saturates and never wraps. It is only meaningful in HALT_REQ and RESUME_WAIT.

Decomposition:
- Package debug_ctrl_pkg holds:
  - cmd_op_e (NOP/HALT/RESUME/ACK_RESET).
  - rsp_status_e (OK/TIMEOUT/ERR_STATE).
  - dbg_state_e (3-bit state encoding).
- One sub-module, dbg_timeout_cnt: clear/enable inputs and an expired flag at TIMEOUT_CYCLES-1. It is parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then HALT; core raises halted_i 3 cycles after debug_req_o rises -> debug_req_o high exactly 3 cycles, rsp OK, state HALTED, cmd_ready_o=1.
- HALT with halted_i never asserted, TIMEOUT_CYCLES=64 -> debug_req_o high exactly 64 cycles, rsp TIMEOUT, state IDLE.
- From HALTED, RESUME; running_i=1 and halted_i=0 after 5 cycles -> rsp OK, state IDLE. RESUME issued in IDLE -> rsp ERR_STATE, no debug_req_o activity.
- havereset_i pulsed 1 cycle -> sticky=1. ACK_RESET accepted on the same cycle as a second havereset_i pulse -> sticky remains 1. A following ACK_RESET -> sticky=0, rsp OK.
- rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and rsp_status_o stable, cmd_ready_o=0. rst asserted during HALT_REQ -> next edge debug_req_o=0, rsp_valid_o=0, state IDLE.
- halted_i rises in IDLE without a command, then HALT accepted the same cycle -> state HALTED, immediate rsp OK, debug_req_o never asserted.
